awmf_reg_slave_chain: RTL and testbench

Parametrised successor to the single-register daisy-chain product-ID slave model. It runs in one system clock domain and oversamples the SPI pins (sclk, cs_n, sdi). It decodes a read/write header and serves a small register bank: the product ID plus writable config words. Non-addressed traffic passes through with a fixed chain delay. It is instantiated N times in series in AWMF chain sims and is synthesizable for FPGA emulation.

---
 rtl/awmf_reg_slave_chain.sv | 187 ++++++++++++++++++
 tb/tb_awmf_reg_slave_chain.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/awmf_reg_slave_chain.sv
// Daisy-chain SPI register slave: oversamples the SPI pins, serves a small register bank
// (product ID plus RW config words) and passes foreign traffic through a fixed bit delay.
module awmf_reg_slave_chain #(
  parameter int                    ADDR_BITS    = 10,
  parameter int                    DATA_BITS    = 48,
  parameter int                    HDR_BITS     = 12,
  parameter int                    NUM_REGS     = 4,
  parameter logic [ADDR_BITS-1:0]  REG_BASE     = 10'h055,
  parameter logic [DATA_BITS-1:0]  PROD_ID_DATA = 48'hABCD_EF01_2345,
  parameter int                    CHAIN_DLY    = 60,
  parameter int                    SYNC_STAGES  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sclk,
  input  logic                               cs_n,
  input  logic                               sdi,
  output logic                               sdo,
  output logic [(NUM_REGS-1)*DATA_BITS-1:0]  cfg_regs,
  output logic                               wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]        wr_idx,
  output logic                               frame_err
);

  localparam int OP_BITS  = HDR_BITS - ADDR_BITS;
  localparam int IDX_BITS = $clog2(NUM_REGS);
  localparam int CNT_W    = 8;
  localparam int RD_W     = $clog2(DATA_BITS + 1);
  localparam int FULL_LEN = HDR_BITS + DATA_BITS;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10
  } op_e;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic                   sclk_d, cs_d, armed;
  logic                   sclk_s, cs_s, sdi_s;
  logic                   in_frame, rise, fall, cs_rise;

  logic [CNT_W-1:0]       rise_cnt;
  logic [HDR_BITS-1:0]    hdr_sh, hdr_next;
  logic [DATA_BITS-1:0]   win_sh, dout, read_word;
  logic [CHAIN_DLY-1:0]   chain;
  logic                   pt_bit;
  logic [RD_W-1:0]        rd_left;
  op_e                    op, op_next;
  logic                   hit, hit_next;
  logic [IDX_BITS-1:0]    idx, idx_next;
  logic [ADDR_BITS-1:0]   addr_next, offset;
  logic [OP_BITS-1:0]     opf_next;
  logic [DATA_BITS-1:0]   cfg_mem [1:NUM_REGS-1];

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign in_frame = armed & ~cs_s;
  assign rise     = in_frame & sclk_s & ~sclk_d;
  assign fall     = in_frame & ~sclk_s & sclk_d;
  assign cs_rise  = cs_s & ~cs_d;

  // sdi goes through the same depth as sclk so the sampled bit lines up with the pin edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      if (cs_s) armed <= 1'b1;
    end
  end

  assign hdr_next  = {hdr_sh[HDR_BITS-2:0], sdi_s};
  assign addr_next = hdr_next[ADDR_BITS-1:0];
  assign opf_next  = hdr_next[HDR_BITS-1:ADDR_BITS];
  assign offset    = addr_next - REG_BASE;
  assign hit_next  = (addr_next >= REG_BASE) && (offset < ADDR_BITS'(NUM_REGS));
  assign idx_next  = offset[IDX_BITS-1:0];

  always_comb begin
    op_next = OP_NOP;
    if (opf_next == OP_BITS'(2))      op_next = OP_READ;
    else if (opf_next == OP_BITS'(1)) op_next = OP_WRITE;
  end

  always_comb begin
    read_word = '0;
    if (hit_next) begin
      if (idx_next == '0) read_word = PROD_ID_DATA;
      else begin
        for (int i = 1; i < NUM_REGS; i++)
          if (idx_next == IDX_BITS'(i)) read_word = cfg_mem[i];
      end
    end
  end

  // Frame datapath: header/window shifters, read serializer and pass-through chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_cnt <= '0;
      hdr_sh   <= '0;
      win_sh   <= '0;
      chain    <= '0;
      pt_bit   <= 1'b0;
      dout     <= '0;
      rd_left  <= '0;
      op       <= OP_NOP;
      hit      <= 1'b0;
      idx      <= '0;
      sdo      <= 1'b0;
    end else if (!in_frame) begin
      rise_cnt <= '0;
      hdr_sh   <= '0;
      win_sh   <= '0;
      chain    <= '0;
      rd_left  <= '0;
      op       <= OP_NOP;
      sdo      <= 1'b0;
    end else begin
      if (rise) begin
        if (rise_cnt != '1) rise_cnt <= rise_cnt + CNT_W'(1);
        pt_bit <= sdi_s;
        if (rise_cnt < CNT_W'(HDR_BITS)) hdr_sh <= hdr_next;
        if (rise_cnt == CNT_W'(HDR_BITS - 1)) begin
          op  <= op_next;
          hit <= hit_next;
          idx <= idx_next;
          if (op_next == OP_READ) begin
            dout    <= read_word;
            rd_left <= RD_W'(DATA_BITS);
          end
        end
        if (rise_cnt >= CNT_W'(HDR_BITS) && rise_cnt < CNT_W'(FULL_LEN))
          win_sh <= {win_sh[DATA_BITS-2:0], sdi_s};
      end
      if (fall) begin
        chain <= {chain[CHAIN_DLY-2:0], pt_bit};
        if (rd_left != '0) begin
          sdo     <= dout[DATA_BITS-1];
          dout    <= {dout[DATA_BITS-2:0], 1'b0};
          rd_left <= rd_left - RD_W'(1);
        end else begin
          sdo <= chain[CHAIN_DLY-1];
        end
      end
    end
  end

  // Writes commit only when the frame closes; the registers still hold the last frame's values here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) cfg_mem[i] <= '0;
      wr_pulse  <= 1'b0;
      wr_idx    <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      if (cs_rise && op == OP_WRITE) begin
        if (rise_cnt >= CNT_W'(FULL_LEN)) begin
          if (hit && idx != '0) begin
            for (int i = 1; i < NUM_REGS; i++)
              if (idx == IDX_BITS'(i)) cfg_mem[i] <= win_sh;
            wr_pulse <= 1'b1;
            wr_idx   <= idx;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_regs[(g-1)*DATA_BITS +: DATA_BITS] = cfg_mem[g];
  end

endmodule

// File: tb/tb_awmf_reg_slave_chain.sv
// Self-checking bench for awmf_reg_slave_chain: directed frames plus random frames checked
// against a frame-level model of the register bank and pass-through delay.
module tb_awmf_reg_slave_chain;

  localparam logic [47:0] PROD = 48'hABCD_EF01_2345;

  logic         clk = 1'b0;
  logic         rst, sclk, cs_n, sdi;
  logic         sdo;
  logic [143:0] cfg_regs;
  logic         wr_pulse;
  logic [1:0]   wr_idx;
  logic         frame_err;

  int           checks = 0;
  int           errors = 0;
  logic         fb [1:255];
  logic [47:0]  mregs [1:3];
  int           last_idx;
  logic [47:0]  rd_capture;
  int           pulse_cnt, err_cnt;

  always #5 clk = ~clk;

  awmf_reg_slave_chain dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .sdi       (sdi),
    .sdo       (sdo),
    .cfg_regs  (cfg_regs),
    .wr_pulse  (wr_pulse),
    .wr_idx    (wr_idx),
    .frame_err (frame_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic buildFrame(input logic [11:0] hdr, input logic [47:0] data, input int n);
    for (int i = 1; i <= 12; i++) fb[i] = hdr[12-i];
    for (int i = 13; i <= 60; i++) fb[i] = data[60-i];
    for (int i = 61; i <= n; i++) fb[i] = 1'($urandom_range(0, 1));
  endtask

  // Drives one frame of n bits (optional 1-clk reset after bit rst_at) and checks it against the model.
  task automatic applyStimulus(input int n, input int rst_at);
    logic [11:0] hdr;
    logic [47:0] dout, wdata;
    int          op, a, idx, ep, ee;
    bit          hit, aborted;
    logic        exp;

    hdr = '0;
    for (int i = 1; i <= 12; i++) hdr = {hdr[10:0], (i <= n) ? fb[i] : 1'b0};
    op  = (n >= 12) ? int'(hdr[11:10]) : 0;
    a   = int'(hdr[9:0]);
    hit = (a >= 85) && (a < 89);
    idx = a - 85;
    dout = '0;
    if (op == 2 && hit) begin
      if (idx == 0) dout = PROD;
      else          dout = mregs[idx];
    end
    wdata = '0;
    for (int i = 13; i <= 60; i++) wdata = {wdata[46:0], (i <= n) ? fb[i] : 1'b0};
    aborted    = 1'b0;
    rd_capture = '0;

    @(negedge clk) cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 1; k <= n; k++) begin
      sdi = fb[k];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
      repeat (5) @(negedge clk);
      if (aborted)                         exp = 1'b0;
      else if (op == 2 && k >= 12 && k <= 59) exp = dout[59-k];
      else if (k > 60)                     exp = fb[k-60];
      else                                 exp = 1'b0;
      if (k >= 12 && k <= 59) rd_capture[59-k] = sdo;
      checkOutput("sdo_fall", 64'(sdo), 64'(exp));
      checkOutput("idle_pulse", 64'({wr_pulse, frame_err}), 64'(0));
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        for (int r = 1; r <= 3; r++) mregs[r] = '0;
        last_idx = 0;
        @(negedge clk);
        checkOutput("rst_sdo", 64'(sdo), 64'(0));
        checkOutput("rst_cfg_zero", 64'(|cfg_regs), 64'(0));
      end
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;

    pulse_cnt = 0;
    err_cnt   = 0;
    ep        = 0;
    ee        = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_pulse) begin
        pulse_cnt++;
        checkOutput("wr_idx_at_pulse", 64'(wr_idx), 64'(idx));
      end
      if (frame_err) err_cnt++;
    end
    if (!aborted && op == 1) begin
      if (n >= 60) begin
        if (hit && idx != 0) begin
          ep = 1;
          mregs[idx] = wdata;
          last_idx   = idx;
        end
      end else begin
        ee = 1;
      end
    end
    checkOutput("wr_pulse_cycles", 64'(pulse_cnt), 64'(ep));
    checkOutput("frame_err_cycles", 64'(err_cnt), 64'(ee));
    checkOutput("wr_idx_held", 64'(wr_idx), 64'(last_idx));
    checkOutput("sdo_idle", 64'(sdo), 64'(0));
    for (int r = 1; r <= 3; r++)
      checkOutput("cfg_word", 64'(cfg_regs[(r-1)*48 +: 48]), 64'(mregs[r]));
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    sdi  = 1'b0;
    for (int r = 1; r <= 3; r++) mregs[r] = '0;
    last_idx = 0;
    repeat (4) @(negedge clk);
    checkOutput("reset_sdo", 64'(sdo), 64'(0));
    checkOutput("reset_pulses", 64'({wr_pulse, frame_err}), 64'(0));
    checkOutput("reset_wr_idx", 64'(wr_idx), 64'(0));
    checkOutput("reset_cfg", 64'(|cfg_regs), 64'(0));
    rst = 1'b0;
    repeat (8) @(negedge clk);

    buildFrame(12'h855, 48'h0, 60);
    applyStimulus(60, 0);
    checkOutput("prod_id_literal", 64'(rd_capture), 64'(48'hABCD_EF01_2345));

    buildFrame(12'h457, 48'h0123_4567_89AB, 60);
    applyStimulus(60, 0);
    checkOutput("wr2_literal", 64'(cfg_regs[95:48]), 64'(48'h0123_4567_89AB));
    checkOutput("wr_idx_literal", 64'(wr_idx), 64'(2));

    buildFrame(12'h857, 48'h0, 60);
    applyStimulus(60, 0);
    checkOutput("rd2_literal", 64'(rd_capture), 64'(48'h0123_4567_89AB));

    buildFrame(12'h456, 48'h5A5A_A5A5_F00F, 42);
    applyStimulus(42, 0);
    checkOutput("short_err_literal", 64'(err_cnt), 64'(1));

    buildFrame(12'h000, 48'({$urandom, $urandom}), 120);
    applyStimulus(120, 0);

    buildFrame(12'h455, 48'hFFFF_FFFF_FFFF, 60);
    applyStimulus(60, 0);
    checkOutput("ro_no_pulse_literal", 64'(pulse_cnt + err_cnt), 64'(0));
    buildFrame(12'h855, 48'h0, 60);
    applyStimulus(60, 0);
    checkOutput("ro_prod_literal", 64'(rd_capture), 64'(48'hABCD_EF01_2345));

    buildFrame(12'h456, 48'h1111_2222_3333, 60);
    applyStimulus(60, 30);
    checkOutput("rst_abort_literal", 64'(|cfg_regs), 64'(0));
    buildFrame(12'h456, 48'h7654_3210_FEDC, 60);
    applyStimulus(60, 0);
    checkOutput("post_rst_literal", 64'(cfg_regs[47:0]), 64'(48'h7654_3210_FEDC));

    for (int f = 0; f < 20; f++) begin
      logic [1:0] opv;
      logic [9:0] av;
      int         r, n;
      if ($urandom_range(0, 3) == 0) opv = 2'($urandom_range(0, 3));
      else                           opv = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      av = 10'(83 + $urandom_range(0, 7));
      r  = int'($urandom_range(0, 3));
      if (r == 0)      n = int'($urandom_range(1, 59));
      else if (r == 1) n = int'($urandom_range(61, 90));
      else             n = 60;
      buildFrame({opv, av}, 48'({$urandom, $urandom}), n);
      applyStimulus(n, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
